// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised raster timing generator. Divides the system clock
//             down to a pixel strobe, walks a (hCount, vCount) beam position
//             through active / front porch / sync / back porch, and drives
//             sync, blanking, line/frame start pulses and a lead-ahead fetch
//             position for memories with LEAD pixels of read latency.
//  Ports    : clk        - system clock
//             reset      - synchronous active-high reset
//             pixEn      - one-clk pixel strobe (first clk of each pixel)
//             hCount     - current column, 0..H_TOTAL-1
//             vCount     - current line, 0..V_TOTAL-1
//             hSync      - horizontal sync, active level = SYNC_POL
//             vSync      - vertical sync, active level = SYNC_POL
//             bright     - beam is inside the active area
//             frameStart - one-clk pulse when position becomes (0,0)
//             lineStart  - one-clk pulse when hCount becomes 0
//             fetchH     - column LEAD pixels ahead in raster order
//             fetchV     - line of the fetch position
//             fetchValid - fetch position is inside the active area
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_POL = 0,
  parameter int CLK_DIV  = 2,
  parameter int LEAD     = 2,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pixEn,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic             frameStart,
  output logic             lineStart,
  output logic [CNT_W-1:0] fetchH,
  output logic [CNT_W-1:0] fetchV,
  output logic             fetchValid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  // Sync windows use an inclusive last value so that a window ending exactly
  // at the line/frame end never needs a constant wider than CNT_W.
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  // The fetch pair sits one pixel before (LEAD mod frame) during reset, so
  // the first strobe after release lands it exactly LEAD pixels ahead.
  localparam int RST_IDX = (LEAD == 0) ? (FRAME - 1) : (LEAD - 1);
  localparam int RST_FH_I = RST_IDX % H_TOTAL;
  localparam int RST_FV_I = RST_IDX / H_TOTAL;
  localparam logic [CNT_W-1:0] RST_FH  = CNT_W'(RST_FH_I);
  localparam logic [CNT_W-1:0] RST_FV  = CNT_W'(RST_FV_I);
  localparam logic RST_FVALID = (RST_FH_I < H_ACTIVE) && (RST_FV_I < V_ACTIVE);

  localparam logic SYNC_ACT = 1'(SYNC_POL);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             tick;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic [CNT_W-1:0] fh_next;
  logic [CNT_W-1:0] fv_next;

  // Next-position logic; every registered output is derived from these so
  // outputs change in the same clk as the position itself.
  always_comb begin
    tick     = (div_cnt == DIV_MAX);
    div_next = tick ? '0 : div_cnt + 1'b1;

    h_next = hCount;
    v_next = vCount;
    if (tick) begin
      if (hCount == H_MAX) begin
        h_next = '0;
        v_next = (vCount == V_MAX) ? '0 : vCount + 1'b1;
      end else begin
        h_next = hCount + 1'b1;
      end
    end

    fh_next = fetchH;
    fv_next = fetchV;
    if (tick) begin
      if (fetchH == H_MAX) begin
        fh_next = '0;
        fv_next = (fetchV == V_MAX) ? '0 : fetchV + 1'b1;
      end else begin
        fh_next = fetchH + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= DIV_MAX;
      hCount     <= H_MAX;
      vCount     <= V_MAX;
      fetchH     <= RST_FH;
      fetchV     <= RST_FV;
      fetchValid <= RST_FVALID;
      pixEn      <= 1'b0;
      bright     <= 1'b0;
      frameStart <= 1'b0;
      lineStart  <= 1'b0;
      hSync      <= ~SYNC_ACT;
      vSync      <= ~SYNC_ACT;
    end else begin
      div_cnt    <= div_next;
      hCount     <= h_next;
      vCount     <= v_next;
      fetchH     <= fh_next;
      fetchV     <= fv_next;
      pixEn      <= tick;
      hSync      <= ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
      vSync      <= ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ACT : ~SYNC_ACT;
      bright     <= (h_next < H_ACT) && (v_next < V_ACT);
      fetchValid <= (fh_next < H_ACT) && (fv_next < V_ACT);
      // Pulses qualify on tick so a held position never re-fires them.
      lineStart  <= tick && (h_next == '0);
      frameStart <= tick && (h_next == '0) && (v_next == '0);
    end
  end

endmodule
`default_nettype wire
